// File: rtl/ticket_pkg.sv
// ticket_pkg: shared definitions for the ticket vending controller.
// Holds the FSM state encoding, coin denominations and the default fare
// tariff constants used by ticket_vend_ctrl and fare_calc.
package ticket_pkg;

  // FSM state encoding, also driven out on the 3-bit state port
  typedef enum logic [2:0] {
    ST_SELFTEST = 3'd0,
    ST_IDLE     = 3'd1,
    ST_INPUT    = 3'd2,
    ST_CALC     = 3'd3,
    ST_CHANGE   = 3'd4,
    ST_ISSUE    = 3'd5,
    ST_FAIL     = 3'd6
  } state_t;

  // Value of each coin input, index 0 upwards
  localparam int unsigned COIN_VAL [4] = '{1, 5, 10, 20};

  // Default tariff
  localparam int FARE_BASE_DEF = 3;   // fare for 0..BAND stations
  localparam int BAND_DEF      = 5;   // stations per short band
  localparam int NBANDS_DEF    = 4;   // short bands before the long tariff
  localparam int LONG_STEP_DEF = 10;  // stations per +1 in the long tariff

  // Upper bound of the per-cycle coin sum (all four coins at once)
  localparam int COIN_SUM_W = 7;

endpackage

// File: rtl/fare_calc.sv
// fare_calc: total fare for the current selection.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   en           power switch, low forces the fare to 0
//   sta1, sta10  station count as two BCD digits
//   tickets      number of tickets
//   fare         registered total fare = per-ticket fare * tickets,
//                truncated to PAY_W bits; lags the inputs by one cycle
module fare_calc
  import ticket_pkg::*;
#(
  parameter int PAY_W     = 8,
  parameter int FARE_BASE = FARE_BASE_DEF,
  parameter int BAND      = BAND_DEF,
  parameter int NBANDS    = NBANDS_DEF,
  parameter int LONG_STEP = LONG_STEP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       sta1,
  input  logic [3:0]       sta10,
  input  logic [3:0]       tickets,
  output logic [PAY_W-1:0] fare
);

  localparam int SHORT_MAX = BAND * NBANDS;

  int               stations;
  int               per_ticket;
  int               total;
  logic [PAY_W-1:0] fare_next;

  always_comb begin
    stations = 10 * int'(sta10) + int'(sta1);
    if (stations == 0) begin
      per_ticket = FARE_BASE;
    end else if (stations <= SHORT_MAX) begin
      // ceil(stations / BAND) - 1 extra units within the short bands
      per_ticket = FARE_BASE + (stations + BAND - 1) / BAND - 1;
    end else begin
      per_ticket = FARE_BASE + NBANDS - 1 + (stations - SHORT_MAX) / LONG_STEP;
    end
    total     = per_ticket * int'(tickets);
    fare_next = PAY_W'(total);
  end

  // Recomputed every cycle; with tickets==0 the fare is naturally 0, so it
  // follows any clearing of the selection one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fare <= '0;
    end else if (!en) begin
      fare <= '0;
    end else begin
      fare <= fare_next;
    end
  end

endmodule

// File: rtl/ticket_vend_ctrl.sv
// ticket_vend_ctrl: ticket vending machine controller.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   en                       power switch, low clears everything and re-arms self-test
//   inc_tkt/inc_sta1/inc_sta10  selection pulses (ticket count, station digits)
//   coin[NUM_COINS]          coin insertion pulses, values from COIN_VAL
//   confirm, take_change     user pulses
//   state                    current FSM state (ticket_pkg::state_t encoding)
//   tickets, sta1, sta10     selection counters (BCD digits for stations)
//   amount                   money paid, or change while in CHANGE
//   fare                     registered total fare
//   ticket_pulse             one cycle per issued ticket
//   fail                     high while in FAIL
module ticket_vend_ctrl
  import ticket_pkg::*;
#(
  parameter int NUM_COINS    = 3,
  parameter int PAY_W        = 8,
  parameter int MAX_TKT      = 9,
  parameter int FARE_BASE    = FARE_BASE_DEF,
  parameter int BAND         = BAND_DEF,
  parameter int NBANDS       = NBANDS_DEF,
  parameter int LONG_STEP    = LONG_STEP_DEF,
  parameter int TIMEOUT_CYC  = 8191,
  parameter int SELFTEST_CYC = 1536,
  parameter int ISSUE_GAP    = 256,
  parameter int FAIL_CYC     = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 inc_tkt,
  input  logic                 inc_sta1,
  input  logic                 inc_sta10,
  input  logic [NUM_COINS-1:0] coin,
  input  logic                 confirm,
  input  logic                 take_change,
  output logic [2:0]           state,
  output logic [3:0]           tickets,
  output logic [3:0]           sta1,
  output logic [3:0]           sta10,
  output logic [PAY_W-1:0]     amount,
  output logic [PAY_W-1:0]     fare,
  output logic                 ticket_pulse,
  output logic                 fail
);

  localparam int ST_W   = $clog2(SELFTEST_CYC + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W  = $clog2(ISSUE_GAP + 1);
  localparam int FAIL_W = $clog2(FAIL_CYC + 1);
  localparam int SUM_W  = PAY_W + COIN_SUM_W;

  localparam logic [ST_W-1:0]   ST_LAST   = ST_W'(SELFTEST_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(ISSUE_GAP - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(FAIL_CYC - 1);
  localparam logic [SUM_W-1:0]  PAY_MAX   = SUM_W'((1 << PAY_W) - 1);

  state_t              state_reg;
  logic [3:0]          tickets_reg;
  logic [3:0]          sta1_reg;
  logic [3:0]          sta10_reg;
  logic [PAY_W-1:0]    amount_reg;
  logic                ticket_pulse_reg;
  logic                fail_reg;
  logic [ST_W-1:0]     st_cnt_reg;
  logic [TO_W-1:0]     idle_cnt_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;
  logic [3:0]          issued_reg;
  logic [FAIL_W-1:0]   fail_cnt_reg;

  logic [COIN_SUM_W-1:0] coin_term [NUM_COINS];
  logic [COIN_SUM_W-1:0] coin_sum;
  logic [SUM_W-1:0]      paid_sum;
  logic [PAY_W-1:0]      paid_next;
  logic [3:0]            tickets_next;
  logic [3:0]            sta1_next;
  logic [3:0]            sta10_next;
  logic                  any_pulse;
  logic                  go_idle;

  // ---------------------------------------------------------------------
  // Coin value per input; several coins in one cycle are summed
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_coin
    assign coin_term[gi] = coin[gi] ? COIN_SUM_W'(COIN_VAL[gi]) : '0;
  end

  always_comb begin
    coin_sum = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      coin_sum = coin_sum + coin_term[i];
    end
  end

  // Paid amount saturates at the top of the PAY_W range
  always_comb begin
    paid_sum  = SUM_W'(amount_reg) + SUM_W'(coin_sum);
    paid_next = (paid_sum > PAY_MAX) ? PAY_MAX[PAY_W-1:0] : paid_sum[PAY_W-1:0];
  end

  // Selection counters with wrap-around
  always_comb begin
    tickets_next = tickets_reg;
    sta1_next    = sta1_reg;
    sta10_next   = sta10_reg;
    if (inc_tkt) begin
      tickets_next = (tickets_reg == 4'(MAX_TKT)) ? 4'd0 : tickets_reg + 4'd1;
    end
    if (inc_sta1) begin
      sta1_next = (sta1_reg == 4'd9) ? 4'd0 : sta1_reg + 4'd1;
    end
    if (inc_sta10) begin
      sta10_next = (sta10_reg == 4'd9) ? 4'd0 : sta10_reg + 4'd1;
    end
  end

  assign any_pulse = inc_tkt | inc_sta1 | inc_sta10 | (|coin) | confirm | take_change;

  // Every way back to IDLE that also wipes the transaction
  always_comb begin
    go_idle = 1'b0;
    case (state_reg)
      ST_INPUT, ST_CHANGE: go_idle = !any_pulse && (idle_cnt_reg == TO_LAST);
      ST_ISSUE:            go_idle = (issued_reg == tickets_reg);
      ST_FAIL:             go_idle = (fail_cnt_reg == FAIL_LAST);
      default:             go_idle = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Main FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_SELFTEST;
      tickets_reg      <= '0;
      sta1_reg         <= '0;
      sta10_reg        <= '0;
      amount_reg       <= '0;
      ticket_pulse_reg <= 1'b0;
      fail_reg         <= 1'b0;
      st_cnt_reg       <= '0;
      idle_cnt_reg     <= '0;
      gap_cnt_reg      <= '0;
      issued_reg       <= '0;
      fail_cnt_reg     <= '0;
    end else if (!en) begin
      // Powered off: hold everything at reset values; self-test restarts
      // from zero on the first enabled cycle.
      state_reg        <= ST_SELFTEST;
      tickets_reg      <= '0;
      sta1_reg         <= '0;
      sta10_reg        <= '0;
      amount_reg       <= '0;
      ticket_pulse_reg <= 1'b0;
      fail_reg         <= 1'b0;
      st_cnt_reg       <= '0;
      idle_cnt_reg     <= '0;
      gap_cnt_reg      <= '0;
      issued_reg       <= '0;
      fail_cnt_reg     <= '0;
    end else begin
      ticket_pulse_reg <= 1'b0;
      if (go_idle) begin
        state_reg    <= ST_IDLE;
        tickets_reg  <= '0;
        sta1_reg     <= '0;
        sta10_reg    <= '0;
        amount_reg   <= '0;
        fail_reg     <= 1'b0;
        idle_cnt_reg <= '0;
        gap_cnt_reg  <= '0;
        issued_reg   <= '0;
        fail_cnt_reg <= '0;
      end else begin
        case (state_reg)
          ST_SELFTEST: begin
            if (st_cnt_reg == ST_LAST) begin
              state_reg  <= ST_IDLE;
              st_cnt_reg <= '0;
            end else begin
              st_cnt_reg <= st_cnt_reg + 1'b1;
            end
          end

          ST_IDLE: begin
            // The waking pulse is applied immediately
            if (any_pulse) begin
              state_reg    <= ST_INPUT;
              tickets_reg  <= tickets_next;
              sta1_reg     <= sta1_next;
              sta10_reg    <= sta10_next;
              amount_reg   <= paid_next;
              idle_cnt_reg <= '0;
            end
          end

          ST_INPUT: begin
            if (confirm && (tickets_reg != '0)) begin
              // An accepted confirm freezes the selection: other pulses in
              // the same cycle are dropped so the fare and paid amount
              // compared in CALC belong to the same selection.
              state_reg    <= ST_CALC;
              idle_cnt_reg <= '0;
            end else if (any_pulse) begin
              tickets_reg  <= tickets_next;
              sta1_reg     <= sta1_next;
              sta10_reg    <= sta10_next;
              amount_reg   <= paid_next;
              idle_cnt_reg <= '0;
            end else begin
              idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end
          end

          ST_CALC: begin
            // fare already reflects the frozen selection at this point
            if (amount_reg == fare) begin
              state_reg   <= ST_ISSUE;
              gap_cnt_reg <= '0;
              issued_reg  <= '0;
            end else if (amount_reg > fare) begin
              state_reg    <= ST_CHANGE;
              amount_reg   <= amount_reg - fare;
              idle_cnt_reg <= '0;
            end else begin
              state_reg    <= ST_FAIL;
              fail_reg     <= 1'b1;
              fail_cnt_reg <= '0;
            end
          end

          ST_CHANGE: begin
            if (take_change) begin
              state_reg   <= ST_ISSUE;
              amount_reg  <= '0;
              gap_cnt_reg <= '0;
              issued_reg  <= '0;
            end else if (any_pulse) begin
              idle_cnt_reg <= '0;
            end else begin
              idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end
          end

          ST_ISSUE: begin
            // gap counter at 0 means a ticket is due this cycle
            if (gap_cnt_reg == '0) begin
              ticket_pulse_reg <= 1'b1;
              issued_reg       <= issued_reg + 4'd1;
              gap_cnt_reg      <= GAP_LAST;
            end else begin
              gap_cnt_reg <= gap_cnt_reg - 1'b1;
            end
          end

          ST_FAIL: begin
            fail_cnt_reg <= fail_cnt_reg + 1'b1;
          end

          default: begin
            state_reg <= ST_SELFTEST;
          end
        endcase
      end
    end
  end

  fare_calc #(
    .PAY_W    (PAY_W),
    .FARE_BASE(FARE_BASE),
    .BAND     (BAND),
    .NBANDS   (NBANDS),
    .LONG_STEP(LONG_STEP)
  ) u_fare_calc (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sta1   (sta1_reg),
    .sta10  (sta10_reg),
    .tickets(tickets_reg),
    .fare   (fare)
  );

  assign state        = state_reg;
  assign tickets      = tickets_reg;
  assign sta1         = sta1_reg;
  assign sta10        = sta10_reg;
  assign amount       = amount_reg;
  assign ticket_pulse = ticket_pulse_reg;
  assign fail         = fail_reg;

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// tb_ticket_vend_ctrl: directed and randomized checks of ticket_vend_ctrl
// against a tariff model written directly from the fare rules.
module tb_ticket_vend_ctrl;
  import ticket_pkg::*;

  localparam int NUM_COINS    = 3;
  localparam int PAY_W        = 8;
  localparam int PAY_MOD      = 256;
  localparam int TIMEOUT_CYC  = 8191;
  localparam int SELFTEST_CYC = 1536;
  localparam int ISSUE_GAP    = 256;
  localparam int FAIL_CYC     = 1024;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic                 inc_tkt = 1'b0;
  logic                 inc_sta1 = 1'b0;
  logic                 inc_sta10 = 1'b0;
  logic [NUM_COINS-1:0] coin = '0;
  logic                 confirm = 1'b0;
  logic                 take_change = 1'b0;
  logic [2:0]           state;
  logic [3:0]           tickets;
  logic [3:0]           sta1;
  logic [3:0]           sta10;
  logic [PAY_W-1:0]     amount;
  logic [PAY_W-1:0]     fare;
  logic                 ticket_pulse;
  logic                 fail;

  int n_cmp = 0;
  int n_err = 0;
  int coin_q[$];
  int coin_value [3] = '{1, 5, 10};

  always #5 clk = ~clk;

  ticket_vend_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .inc_tkt     (inc_tkt),
    .inc_sta1    (inc_sta1),
    .inc_sta10   (inc_sta10),
    .coin        (coin),
    .confirm     (confirm),
    .take_change (take_change),
    .state       (state),
    .tickets     (tickets),
    .sta1        (sta1),
    .sta10       (sta10),
    .amount      (amount),
    .fare        (fare),
    .ticket_pulse(ticket_pulse),
    .fail        (fail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 0 tkt, 1 sta1, 2 sta10, 3 confirm, 4 take_change, 5+k coin k
  task automatic do_pulse(input int which);
    case (which)
      0: inc_tkt = 1'b1;
      1: inc_sta1 = 1'b1;
      2: inc_sta10 = 1'b1;
      3: confirm = 1'b1;
      4: take_change = 1'b1;
      default: coin[which-5] = 1'b1;
    endcase
    tick(1);
    inc_tkt = 1'b0; inc_sta1 = 1'b0; inc_sta10 = 1'b0;
    confirm = 1'b0; take_change = 1'b0; coin = '0;
  endtask

  // Per-ticket fare: walk station by station, adding a unit at each band
  // boundary crossed (every BAND up to 20, then every LONG_STEP beyond).
  function automatic int model_per_fare(input int s);
    int f = 3;
    for (int k = 1; k <= s; k++) begin
      if (k <= 20) begin
        if (k > 1 && ((k - 1) % 5) == 0) f++;
      end else if (((k - 20) % 10) == 0) begin
        f++;
      end
    end
    return f;
  endfunction

  task automatic wait_issue(input int t);
    int pulses = 0;
    int first = -1;
    int prev = -1;
    int gap_ok = 1;
    for (int c = 1; c <= t * ISSUE_GAP + 8; c++) begin
      tick(1);
      if (ticket_pulse === 1'b1) begin
        if (pulses == 0) first = c;
        else if (c - prev != ISSUE_GAP) gap_ok = 0;
        prev = c;
        pulses++;
      end
      if (state == ST_IDLE) break;
    end
    chk("issue_count", pulses, t);
    chk("issue_first", first, 1);
    chk("issue_gap", gap_ok, 1);
    chk("issue_end_state", state, ST_IDLE);
    chk("issue_end_tickets", tickets, 0);
    chk("issue_end_amount", amount, 0);
  endtask

  // One full transaction from IDLE; fare_given < 0 means use the model.
  task automatic run_txn(input int t, input int s10, input int s1, input int fare_given);
    int exp_fare, exp_paid;
    exp_fare = (fare_given >= 0) ? fare_given : (model_per_fare(10 * s10 + s1) * t) % PAY_MOD;
    exp_paid = 0;
    foreach (coin_q[i]) exp_paid += coin_value[coin_q[i]];
    if (exp_paid > PAY_MOD - 1) exp_paid = PAY_MOD - 1;
    $display("txn tickets=%0d stations=%0d paid=%0d fare=%0d outcome=%s", t, 10 * s10 + s1,
             exp_paid, exp_fare,
             (exp_paid == exp_fare) ? "issue" : (exp_paid > exp_fare) ? "change" : "reject");
    chk("txn_start_idle", state, ST_IDLE);
    repeat (t) do_pulse(0);
    repeat (s10) do_pulse(2);
    repeat (s1) do_pulse(1);
    foreach (coin_q[i]) do_pulse(5 + coin_q[i]);
    tick(1);
    chk("sel_state", state, ST_INPUT);
    chk("sel_tickets", tickets, t);
    chk("sel_sta10", sta10, s10);
    chk("sel_sta1", sta1, s1);
    chk("sel_paid", amount, exp_paid);
    do_pulse(3);
    chk("calc_state", state, ST_CALC);
    chk("calc_fare", fare, exp_fare);
    tick(1);
    if (exp_paid == exp_fare) begin
      chk("direct_issue_state", state, ST_ISSUE);
      wait_issue(t);
    end else if (exp_paid > exp_fare) begin
      chk("change_state", state, ST_CHANGE);
      chk("change_amount", amount, exp_paid - exp_fare);
      do_pulse(4);
      chk("take_state", state, ST_ISSUE);
      chk("take_amount", amount, 0);
      wait_issue(t);
    end else begin
      chk("reject_state", state, ST_FAIL);
      chk("reject_flag", fail, 1);
      tick(FAIL_CYC - 1);
      chk("reject_hold_state", state, ST_FAIL);
      chk("reject_hold_flag", fail, 1);
      tick(1);
      chk("reject_end_state", state, ST_IDLE);
      chk("reject_end_flag", fail, 0);
      chk("reject_end_amount", amount, 0);
      chk("reject_end_tickets", tickets, 0);
    end
    tick(2);
    chk("txn_end_fare", fare, 0);
  endtask

  initial begin
    int cnt;

    // ---- reset and self-test ----
    #1 rst = 1'b0;
    en = 1'b1;
    #1;
    chk("rst_state", state, ST_SELFTEST);
    chk("rst_pulse", ticket_pulse, 0);
    chk("rst_amount", amount, 0);
    tick(2);
    rst = 1'b1;
    tick(SELFTEST_CYC - 1);
    chk("selftest_hold", state, ST_SELFTEST);
    tick(1);
    chk("selftest_done", state, ST_IDLE);
    chk("idle_tickets", tickets, 0);
    chk("idle_sta1", sta1, 0);
    chk("idle_sta10", sta10, 0);
    chk("idle_amount", amount, 0);
    chk("idle_fare", fare, 0);
    chk("idle_pulse", ticket_pulse, 0);
    chk("idle_fail", fail, 0);

    // ---- directed transactions ----
    coin_q = '{2, 1};
    run_txn(2, 1, 2, 10);
    coin_q = '{2};
    run_txn(1, 2, 5, 6);
    coin_q = '{0, 0, 0};
    run_txn(1, 0, 5, 3);
    coin_q = '{1};
    run_txn(3, 2, 0, 18);

    // ---- simultaneous coins, saturation, inactivity timeout ----
    coin = 3'b110;
    tick(1);
    coin = '0;
    chk("dual_coin_state", state, ST_INPUT);
    chk("dual_coin_amount", amount, 15);
    repeat (23) do_pulse(7);
    chk("tens_245", amount, 245);
    repeat (3) do_pulse(7);
    chk("tens_saturate", amount, 255);
    tick(TIMEOUT_CYC - 1);
    chk("timeout_hold", state, ST_INPUT);
    tick(1);
    chk("timeout_state", state, ST_IDLE);
    chk("timeout_amount", amount, 0);

    // ---- wrap-around, confirm with zero tickets, power switch ----
    repeat (9) do_pulse(0);
    chk("tkt_max", tickets, 9);
    do_pulse(0);
    chk("tkt_wrap", tickets, 0);
    repeat (10) do_pulse(1);
    chk("sta1_wrap", sta1, 0);
    repeat (13) do_pulse(2);
    chk("sta10_wrap", sta10, 3);
    do_pulse(3);
    chk("confirm_zero_tkt", state, ST_INPUT);
    en = 1'b0;
    tick(1);
    chk("en_low_state", state, ST_SELFTEST);
    chk("en_low_sta10", sta10, 0);
    en = 1'b1;
    tick(100);
    do_pulse(0);
    chk("selftest_ignores", tickets, 0);
    tick(SELFTEST_CYC - 102);
    chk("en_selftest_hold", state, ST_SELFTEST);
    tick(1);
    chk("en_selftest_done", state, ST_IDLE);

    // ---- reset while issuing ----
    repeat (3) do_pulse(0);
    coin_q = '{1, 0, 0, 0, 0};
    foreach (coin_q[i]) do_pulse(5 + coin_q[i]);
    tick(1);
    do_pulse(3);
    tick(1);
    chk("rst_issue_state", state, ST_ISSUE);
    tick(1);
    chk("rst_issue_first", ticket_pulse, 1);
    tick(100);
    rst = 1'b0;
    #1;
    chk("rst_mid_state", state, ST_SELFTEST);
    chk("rst_mid_tickets", tickets, 0);
    cnt = 0;
    repeat (600) begin
      tick(1);
      if (ticket_pulse !== 1'b0) cnt++;
    end
    rst = 1'b1;
    repeat (600) begin
      tick(1);
      if (ticket_pulse !== 1'b0) cnt++;
    end
    chk("rst_no_pulses", cnt, 0);
    tick(SELFTEST_CYC - 601);
    chk("rst2_selftest_hold", state, ST_SELFTEST);
    tick(1);
    chk("rst2_selftest_done", state, ST_IDLE);

    // ---- randomized transactions against the tariff model ----
    for (int n = 0; n < 6; n++) begin
      int t, s10, s1, nc;
      t   = $urandom_range(1, 9);
      s10 = $urandom_range(0, 9);
      s1  = $urandom_range(0, 9);
      nc  = $urandom_range(0, 12);
      coin_q.delete();
      for (int k = 0; k < nc; k++) coin_q.push_back($urandom_range(0, 2));
      run_txn(t, s10, s1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
